demod_sequencer: RTL and testbench

Central sequencer for the UART-fed FM demodulator datapath. It assembles received bytes into 32-bit I/Q samples and issues exactly one step strobe per sample to the demod chain (conjugate multiply, average, FIR). After a fixed pipeline latency it captures the 16-bit demod result and streams it back as two bytes to the UART transmitter, honouring the transmitter's busy flag. It replaces the ad-hoc per-stage start/merge-finished strobing with a single point of control, and adds byte-alignment resync and overrun accounting.

---
 rtl/demod_sequencer.sv | 144 ++++++++++++++
 tb/tb_demod_sequencer.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/demod_sequencer.sv
// Central sequencer for the FM demod datapath: packs rx bytes into I/Q samples,
// strobes the demod chain once per sample, and returns the 16-bit result as two tx bytes.
module demod_sequencer #(
  parameter int PIPE_LAT = 4,
  parameter int TIMEOUT  = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_valid_i,
  input  logic [7:0]  rx_data_i,
  output logic [31:0] sample_o,
  output logic        step_o,
  input  logic [15:0] result_i,
  input  logic        tx_busy_i,
  output logic [7:0]  tx_data_o,
  output logic        tx_valid_o,
  output logic [7:0]  overrun_o,
  output logic        busy_o
);

  localparam int IW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_STEP, S_WAIT, S_SEND_HI, S_GAP, S_SEND_LO, S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [1:0]    idx_q, idx_d;
  logic [23:0]   shreg_q, shreg_d;
  logic [IW-1:0] idle_q, idle_d;
  logic [7:0]    wait_q, wait_d;
  logic [15:0]   res_q, res_d;
  logic [31:0]   sample_q, sample_d;
  logic          step_q, step_d;
  logic          tx_valid_q, tx_valid_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic [7:0]    ovr_q, ovr_d;
  logic          sample_ready, timeout;

  assign sample_ready = rx_valid_i && (idx_q == 2'd3);
  // A byte landing on the timeout cycle wins: timeout only fires on an idle cycle.
  assign timeout = !rx_valid_i && (idx_q != 2'd0) && (idle_q == IW'(TIMEOUT - 1));

  always_comb begin
    idx_d   = idx_q;
    shreg_d = shreg_q;
    idle_d  = '0;
    if (rx_valid_i) begin
      idx_d   = idx_q + 2'd1;
      shreg_d = {shreg_q[15:0], rx_data_i};
    end else if (timeout) begin
      idx_d = '0;
    end else if (idx_q != 2'd0) begin
      idle_d = idle_q + IW'(1);
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_d     = wait_q;
    res_d      = res_q;
    sample_d   = sample_q;
    step_d     = 1'b0;
    tx_valid_d = 1'b0;
    tx_data_d  = tx_data_q;
    ovr_d      = ovr_q;
    if (sample_ready && state_q != S_IDLE && ovr_q != 8'hFF) ovr_d = ovr_q + 8'd1;
    case (state_q)
      S_IDLE: if (sample_ready) begin
        sample_d = {shreg_q, rx_data_i};
        step_d   = 1'b1;
        state_d  = S_STEP;
      end
      S_STEP: begin
        wait_d  = 8'(PIPE_LAT);
        state_d = S_WAIT;
      end
      S_WAIT: begin
        wait_d = wait_q - 8'd1;
        // The capture cycle also makes the first send decision so the high byte
        // can go out on the very next cycle when the transmitter is free.
        if (wait_d == 8'd0) begin
          res_d = result_i;
          if (!tx_busy_i) begin
            tx_valid_d = 1'b1;
            tx_data_d  = result_i[15:8];
            state_d    = S_GAP;
          end else begin
            state_d = S_SEND_HI;
          end
        end
      end
      S_SEND_HI: if (!tx_busy_i) begin
        tx_valid_d = 1'b1;
        tx_data_d  = res_q[15:8];
        state_d    = S_GAP;
      end
      S_GAP: state_d = S_SEND_LO;
      S_SEND_LO: if (!tx_busy_i) begin
        tx_valid_d = 1'b1;
        tx_data_d  = res_q[7:0];
        state_d    = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      shreg_q    <= '0;
      idle_q     <= '0;
      wait_q     <= '0;
      res_q      <= '0;
      sample_q   <= '0;
      step_q     <= 1'b0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= '0;
      ovr_q      <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      shreg_q    <= shreg_d;
      idle_q     <= idle_d;
      wait_q     <= wait_d;
      res_q      <= res_d;
      sample_q   <= sample_d;
      step_q     <= step_d;
      tx_valid_q <= tx_valid_d;
      tx_data_q  <= tx_data_d;
      ovr_q      <= ovr_d;
    end
  end

  assign sample_o   = sample_q;
  assign step_o     = step_q;
  assign tx_data_o  = tx_data_q;
  assign tx_valid_o = tx_valid_q;
  assign overrun_o  = ovr_q;
  assign busy_o     = (state_q != S_IDLE);

endmodule

// File: tb/tb_demod_sequencer.sv
// Bench for demod_sequencer: schedule-based reference model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_demod_sequencer;

  localparam int PL = 8;
  localparam int TO = 20;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx_valid_i;
  logic [7:0]  rx_data_i;
  logic [31:0] sample_o;
  logic        step_o;
  logic [15:0] result_i;
  logic        tx_busy_i;
  logic [7:0]  tx_data_o;
  logic        tx_valid_o;
  logic [7:0]  overrun_o;
  logic        busy_o;

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  logic [7:0] tx_log[$];
  int         tx_cyc[$];
  int         step_cnt = 0;
  int         step_cyc = 0;

  demod_sequencer #(.PIPE_LAT(PL), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .rx_valid_i(rx_valid_i), .rx_data_i(rx_data_i),
    .sample_o(sample_o), .step_o(step_o), .result_i(result_i),
    .tx_busy_i(tx_busy_i), .tx_data_o(tx_data_o), .tx_valid_o(tx_valid_o),
    .overrun_o(overrun_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Reference model: a sample accepted at cycle T has step at T+1, result taken at
  // T+1+PL, first tx the cycle after the first free-busy cycle from T+1+PL, second
  // tx the cycle after the first free-busy cycle at least one past the first tx.
  logic [7:0]  bq[$];
  int          m_last, m_t, m_c1, m_c2, m_ovr;
  bit          m_act;
  logic [15:0] m_res;
  logic [31:0] m_sample;
  bit          e_step, e_busy, e_tv;
  logic [7:0]  e_td;

  initial begin
    int n;
    bit bsy, rdy;
    logic [31:0] asm_s;
    m_act = 0; m_t = 0; m_c1 = -1; m_c2 = -1; m_ovr = 0; m_last = 0;
    m_res = '0; m_sample = '0; asm_s = '0;
    e_step = 0; e_busy = 0; e_tv = 0; e_td = '0;
    @(posedge clk);
    forever begin
      @(negedge clk);
      n = cyc;
      chk("step_o", 32'(step_o), 32'(e_step));
      chk("busy_o", 32'(busy_o), 32'(e_busy));
      chk("tx_valid_o", 32'(tx_valid_o), 32'(e_tv));
      chk("sample_o", sample_o, m_sample);
      chk("overrun_o", 32'(overrun_o), 32'(m_ovr));
      if (e_tv) chk("tx_data_o", 32'(tx_data_o), 32'(e_td));
      if (tx_valid_o) begin tx_log.push_back(tx_data_o); tx_cyc.push_back(n); end
      if (step_o) begin step_cnt++; step_cyc = n; end

      bsy = m_act && (n >= m_t + 1) && (m_c2 < 0 || n <= m_c2);
      rdy = 0;
      if (rst) begin
        bq.delete();
        m_act = 0; m_sample = '0; m_ovr = 0; m_c1 = -1; m_c2 = -1;
      end else begin
        if (m_act && n == m_t + 1 + PL) m_res = result_i;
        if (m_act && m_c1 < 0 && n >= m_t + 1 + PL && !tx_busy_i) m_c1 = n + 1;
        else if (m_act && m_c1 >= 0 && m_c2 < 0 && n > m_c1 && !tx_busy_i) m_c2 = n + 1;
        if (rx_valid_i) begin
          bq.push_back(rx_data_i);
          m_last = n;
          if (bq.size() == 4) begin
            asm_s = {bq[0], bq[1], bq[2], bq[3]};
            bq.delete();
            rdy = 1;
          end
        end else if (bq.size() != 0 && n - m_last == TO) begin
          bq.delete();
        end
        if (rdy) begin
          if (!bsy) begin
            m_sample = asm_s; m_act = 1; m_t = n; m_c1 = -1; m_c2 = -1;
          end else if (m_ovr < 255) begin
            m_ovr++;
          end
        end
      end
      e_step = m_act && (n + 1 == m_t + 1);
      e_busy = m_act && (n + 1 >= m_t + 1) && (m_c2 < 0 || n + 1 <= m_c2);
      e_tv   = m_act && (n + 1 == m_c1 || n + 1 == m_c2);
      e_td   = (n + 1 == m_c1) ? m_res[15:8] : m_res[7:0];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    rx_valid_i = 1'b1;
    rx_data_i  = b;
    tick();
    rx_valid_i = 1'b0;
  endtask

  task automatic send_sample(input logic [31:0] s);
    for (int i = 3; i >= 0; i--) send(s[8*i +: 8]);
  endtask

  task automatic wait_step(input int budget, output int at);
    int k = 0;
    while (!step_o && k < budget) begin tick(); k++; end
    chk("wait_step_o", 32'(step_o), 32'(1));
    at = cyc;
  endtask

  task automatic wait_tx(input int budget);
    int k = 0;
    while (!tx_valid_o && k < budget) begin tick(); k++; end
    chk("wait_tx_valid_o", 32'(tx_valid_o), 32'(1));
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_sample"}, sample_o, 32'h0);
    chk({tag, "_step"}, 32'(step_o), 32'h0);
    chk({tag, "_tx_valid"}, 32'(tx_valid_o), 32'h0);
    chk({tag, "_tx_data"}, 32'(tx_data_o), 32'h0);
    chk({tag, "_overrun"}, 32'(overrun_o), 32'h0);
    chk({tag, "_busy"}, 32'(busy_o), 32'h0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t4, s, fall;
    rst = 1'b1; rx_valid_i = 1'b0; rx_data_i = '0; result_i = '0; tx_busy_i = 1'b0;
    tick(); tick(); tick();
    rst = 1'b0;
    chk_zero_outputs("reset");

    // Basic sample with 16-cycle byte spacing
    result_i = 16'hBEEF;
    send(8'h12); repeat (15) tick();
    send(8'h34); repeat (15) tick();
    send(8'h56); repeat (15) tick();
    t4 = cyc;
    send(8'h78);
    repeat (30) tick();
    chk("basic_sample", sample_o, 32'h12345678);
    chk("basic_step_cnt", 32'(step_cnt), 32'd1);
    chk("basic_step_cyc", 32'(step_cyc), 32'(t4 + 1));
    chk("basic_tx_cnt", 32'(tx_log.size()), 32'd2);
    chk("basic_tx_hi", 32'(tx_log[0]), 32'hBE);
    chk("basic_tx_lo", 32'(tx_log[1]), 32'hEF);
    chk("basic_tx1_cyc", 32'(tx_cyc[0]), 32'(t4 + 2 + PL));
    chk("basic_tx2_cyc", 32'(tx_cyc[1]), 32'(t4 + 4 + PL));

    // Busy handshake: hold busy 100 cycles after the first strobe
    tx_log.delete(); tx_cyc.delete();
    send_sample(32'h01020304);
    wait_tx(40);
    tick();
    tx_busy_i = 1'b1;
    repeat (100) tick();
    tx_busy_i = 1'b0;
    fall = cyc;
    repeat (10) tick();
    chk("busy_tx_cnt", 32'(tx_log.size()), 32'd2);
    chk("busy_tx_lo", 32'(tx_log[1]), 32'hEF);
    chk("busy_tx2_cyc", 32'(tx_cyc[1]), 32'(fall + 1));
    chk("busy_tx_gap", 32'(tx_cyc[1] - tx_cyc[0]), 32'd102);

    // Resync: two stale bytes, idle past the timeout
    step_cnt = 0;
    send(8'h01); send(8'h02);
    repeat (25) tick();
    send_sample(32'hAABBCCDD);
    repeat (25) tick();
    chk("resync_sample", sample_o, 32'hAABBCCDD);
    chk("resync_step_cnt", 32'(step_cnt), 32'd1);

    // Byte arriving exactly on the timeout cycle is kept
    step_cnt = 0;
    send(8'h11);
    repeat (TO - 1) tick();
    send(8'h22); send(8'h33); send(8'h44);
    repeat (25) tick();
    chk("collide_sample", sample_o, 32'h11223344);
    chk("collide_step_cnt", 32'(step_cnt), 32'd1);

    // Overrun with the transmitter stuck busy
    tx_log.delete(); tx_cyc.delete();
    tx_busy_i = 1'b1;
    send_sample(32'hC0C1C2C3);
    send_sample(32'hD0D1D2D3);
    send_sample(32'hE0E1E2E3);
    repeat (20) tick();
    chk("ovr_count2", 32'(overrun_o), 32'd2);
    chk("ovr_sample", sample_o, 32'hC0C1C2C3);
    chk("ovr_busy", 32'(busy_o), 32'd1);
    chk("ovr_no_tx", 32'(tx_log.size()), 32'd0);
    for (int i = 0; i < 300; i++) send_sample(32'(i));
    chk("ovr_saturate", 32'(overrun_o), 32'd255);
    chk("ovr_sample_held", sample_o, 32'hC0C1C2C3);

    rst = 1'b1; tick(); rst = 1'b0; tx_busy_i = 1'b0;
    chk_zero_outputs("ovr_reset");

    // Reset in the middle of WAIT
    tx_log.delete(); tx_cyc.delete();
    result_i = 16'h1234;
    send_sample(32'h55667788);
    wait_step(10, s);
    tick(); tick(); tick();
    rst = 1'b1; tick(); rst = 1'b0;
    chk_zero_outputs("midwait_reset");
    repeat (30) tick();
    chk("midwait_no_tx", 32'(tx_log.size()), 32'd0);

    result_i = 16'hC3A5;
    send_sample(32'h0F1E2D3C);
    repeat (30) tick();
    chk("fresh_sample", sample_o, 32'h0F1E2D3C);
    chk("fresh_tx_cnt", 32'(tx_log.size()), 32'd2);
    chk("fresh_tx_hi", 32'(tx_log[0]), 32'hC3);
    chk("fresh_tx_lo", 32'(tx_log[1]), 32'hA5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
